instr_fetch: RTL

Instruction-fetch stage that sits directly upstream of `CPU` and drives its `Instruction` input. It holds a word-addressed instruction memory, a program counter and a one-entry output register with a valid/ready handshake. It also accepts branch redirects from the execute side and stops on a halt word. The memory is loaded through a write port before or during a run.

---
 rtl/instr_fetch.sv | 101 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: word-addressed instruction memory, program counter and a
// one-entry output register with valid/ready handshake, branch redirect and halt detection.
module instr_fetch #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    input  logic              run,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       Instruction,
    output logic [31:0]       pc_out,
    output logic              halted
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_out_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_halted;
    logic [31:0] r_mem [0:DEPTH-1];

    logic [31:0] w_rdata;
    logic        w_slot_free;
    logic        w_unused;

    // Read is combinational off the PC, so a same-edge write is seen only from the next cycle.
    assign w_rdata     = r_mem[r_pc[ADDR_W+1:2]];
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_unused    = &{1'b0, branch_target[1:0]};

    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_mem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_instr     <= 32'd0;
            r_pc_out    <= 32'd0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // A redirect flushes the held entry even if downstream never took it.
                    if (branch_taken) begin
                        r_pc        <= {branch_target[31:2], 2'b00};
                        r_out_valid <= 1'b0;
                    end else if (w_slot_free) begin
                        if (w_rdata == HALT_WORD) begin
                            r_state     <= S_HALT;
                            r_out_valid <= 1'b0;
                            r_halted    <= 1'b1;
                        end else begin
                            r_instr     <= w_rdata;
                            r_pc_out    <= r_pc;
                            r_out_valid <= 1'b1;
                            r_pc        <= r_pc + 32'd4;
                        end
                    end
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign Instruction = r_instr;
    assign pc_out      = r_pc_out;
    assign halted      = r_halted;

endmodule
